// File: rtl/cnt_wrap_cascade.sv
// Downstream checker for a modulo-N counter: verifies each sampled step, locks onto a
// clean sequence, and counts wraps in a modulo-HI_MOD digit with wrap/carry pulses.
//
// state  | meaning
// IDLE   | no reference sample yet; first valid sample seeds prev
// ACQ    | counting consecutive correct steps toward lock
// LOCKED | sequence trusted; wraps advance hi_count, mismatches raise seq_err
module cnt_wrap_cascade #(
  parameter int W      = 4,
  parameter int LOAD   = 10,
  parameter int TERM   = 0,
  parameter int DIR    = 1,
  parameter int HI_MOD = 6,
  parameter int HI_W   = 4,
  parameter int N_LOCK = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cnt_valid,
  input  logic [W-1:0]    cnt_in,
  input  logic            err_clr,
  output logic [HI_W-1:0] hi_count,
  output logic            wrap_pulse,
  output logic            carry,
  output logic            locked,
  output logic            seq_err
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam int RANGE_LO = (LOAD < TERM) ? LOAD : TERM;
  localparam int RANGE_HI = (LOAD < TERM) ? TERM : LOAD;

  localparam logic [W:0]      LOAD_X  = (W+1)'(LOAD);
  localparam logic [W:0]      LO_X    = (W+1)'(RANGE_LO);
  localparam logic [W-1:0]    TERM_V  = W'(TERM);
  localparam logic [W-1:0]    SPAN    = W'(RANGE_HI - RANGE_LO);
  localparam logic [2:0]      LOCK_N  = 3'(N_LOCK);
  localparam logic [HI_W-1:0] HI_LAST = HI_W'(HI_MOD - 1);

  state_t          state, state_nx;
  logic [W-1:0]    prev, prev_nx;
  logic [2:0]      step, step_nx;
  logic [HI_W-1:0] hi_nx;
  logic            wrap_nx, carry_nx, err_nx;

  logic [W:0]      cnt_x, offs, exp_x;
  logic [2:0]      step_inc;
  logic            in_range, match, wrap_ev, set_err;

  // One extra bit keeps prev-1 at 0 from aliasing onto 2^W-1.
  always_comb begin
    cnt_x    = {1'b0, cnt_in};
    offs     = cnt_x - LO_X;
    in_range = !offs[W] && (offs[W-1:0] <= SPAN);
    if (prev == TERM_V)
      exp_x = LOAD_X;
    else if (DIR != 0)
      exp_x = {1'b0, prev} - (W+1)'(1);
    else
      exp_x = {1'b0, prev} + (W+1)'(1);
    match    = in_range && (cnt_x == exp_x);
    wrap_ev  = match && (prev == TERM_V);
    step_inc = step + 3'd1;
  end

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    step_nx  = step;
    hi_nx    = hi_count;
    wrap_nx  = 1'b0;
    carry_nx = 1'b0;
    set_err  = 1'b0;
    if (cnt_valid) begin
      prev_nx = cnt_in;
      case (state)
        IDLE: begin
          state_nx = ACQ;
          step_nx  = 3'd0;
        end
        ACQ: begin
          if (match) begin
            step_nx = step_inc;
            if (step_inc == LOCK_N) state_nx = LOCKED;
          end else begin
            step_nx = 3'd0;
          end
        end
        LOCKED: begin
          if (!match) begin
            set_err  = 1'b1;
            state_nx = ACQ;
            step_nx  = 3'd0;
          end else if (wrap_ev) begin
            wrap_nx = 1'b1;
            if (hi_count == HI_LAST) begin
              hi_nx    = '0;
              carry_nx = 1'b1;
            end else begin
              hi_nx = hi_count + HI_W'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // A fresh mismatch outranks a simultaneous clear.
    err_nx = set_err | (seq_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      step       <= 3'd0;
      hi_count   <= '0;
      wrap_pulse <= 1'b0;
      carry      <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      step       <= step_nx;
      hi_count   <= hi_nx;
      wrap_pulse <= wrap_nx;
      carry      <= carry_nx;
      seq_err    <= err_nx;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_cnt_wrap_cascade.sv
// Bench for cnt_wrap_cascade: three configurations (down 10..0, up 0..10, preset 5..15)
// checked by a behavioural model feeding a scoreboard queue, plus directed spot checks.
module tb_cnt_wrap_cascade;

  logic       clk = 1'b0;
  logic       rst;
  logic       cv [3];
  logic [3:0] ci [3];
  logic       ec [3];
  logic [3:0] hc [3];
  logic       wp [3];
  logic       cy [3];
  logic       lk [3];
  logic       se [3];

  always #5 clk = ~clk;

  cnt_wrap_cascade #(.LOAD(10), .TERM(0), .DIR(1)) u_down (
    .clk(clk), .rst(rst), .cnt_valid(cv[0]), .cnt_in(ci[0]), .err_clr(ec[0]),
    .hi_count(hc[0]), .wrap_pulse(wp[0]), .carry(cy[0]), .locked(lk[0]), .seq_err(se[0]));
  cnt_wrap_cascade #(.LOAD(0), .TERM(10), .DIR(0)) u_up (
    .clk(clk), .rst(rst), .cnt_valid(cv[1]), .cnt_in(ci[1]), .err_clr(ec[1]),
    .hi_count(hc[1]), .wrap_pulse(wp[1]), .carry(cy[1]), .locked(lk[1]), .seq_err(se[1]));
  cnt_wrap_cascade #(.LOAD(5), .TERM(15), .DIR(0)) u_pre (
    .clk(clk), .rst(rst), .cnt_valid(cv[2]), .cnt_in(ci[2]), .err_clr(ec[2]),
    .hi_count(hc[2]), .wrap_pulse(wp[2]), .carry(cy[2]), .locked(lk[2]), .seq_err(se[2]));

  typedef struct {
    int d;
    int hi;
    bit wrap;
    bit carry;
    bit lock;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  int cfg_load [3] = '{10, 0, 5};
  int cfg_term [3] = '{0, 10, 15};
  int cfg_dir  [3] = '{1, 0, 0};
  int m_state  [3];
  int m_prev   [3];
  int m_step   [3];
  int m_hi     [3];
  bit m_err    [3];

  // Scoreboard: compare every queued expectation one tick after the edge it belongs to.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      n_tests++;
      if (hc[sb_e.d] !== 4'(sb_e.hi)) begin
        n_fail++;
        $display("FAIL sb_hi_count dut%0d got %0d want %0d", sb_e.d, hc[sb_e.d], sb_e.hi);
      end
      n_tests++;
      if (wp[sb_e.d] !== sb_e.wrap) begin
        n_fail++;
        $display("FAIL sb_wrap_pulse dut%0d got %0b want %0b", sb_e.d, wp[sb_e.d], sb_e.wrap);
      end
      n_tests++;
      if (cy[sb_e.d] !== sb_e.carry) begin
        n_fail++;
        $display("FAIL sb_carry dut%0d got %0b want %0b", sb_e.d, cy[sb_e.d], sb_e.carry);
      end
      n_tests++;
      if (lk[sb_e.d] !== sb_e.lock) begin
        n_fail++;
        $display("FAIL sb_locked dut%0d got %0b want %0b", sb_e.d, lk[sb_e.d], sb_e.lock);
      end
      n_tests++;
      if (se[sb_e.d] !== sb_e.err) begin
        n_fail++;
        $display("FAIL sb_seq_err dut%0d got %0b want %0b", sb_e.d, se[sb_e.d], sb_e.err);
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_state[d] = 0;
      m_prev[d]  = 0;
      m_step[d]  = 0;
      m_hi[d]    = 0;
      m_err[d]   = 1'b0;
    end
  endtask

  // Behavioural reference: plain integer arithmetic, so no width wrap on the expected value.
  task automatic model(input int d, input bit v, input int x, input bit clr, output exp_t e);
    int lo, hi, nxt;
    bit ok, wr, set_err;
    e.wrap  = 1'b0;
    e.carry = 1'b0;
    set_err = 1'b0;
    if (v) begin
      lo  = (cfg_load[d] < cfg_term[d]) ? cfg_load[d] : cfg_term[d];
      hi  = (cfg_load[d] < cfg_term[d]) ? cfg_term[d] : cfg_load[d];
      if (m_prev[d] == cfg_term[d]) nxt = cfg_load[d];
      else if (cfg_dir[d] != 0)     nxt = m_prev[d] - 1;
      else                          nxt = m_prev[d] + 1;
      ok = (x >= lo) && (x <= hi) && (x == nxt);
      wr = ok && (m_prev[d] == cfg_term[d]);
      case (m_state[d])
        0: begin
          m_state[d] = 1;
          m_step[d]  = 0;
        end
        1: begin
          if (ok) begin
            m_step[d]++;
            if (m_step[d] == 3) m_state[d] = 2;
          end else begin
            m_step[d] = 0;
          end
        end
        default: begin
          if (!ok) begin
            set_err    = 1'b1;
            m_state[d] = 1;
            m_step[d]  = 0;
          end else if (wr) begin
            e.wrap = 1'b1;
            if (m_hi[d] == 5) begin
              m_hi[d] = 0;
              e.carry = 1'b1;
            end else begin
              m_hi[d]++;
            end
          end
        end
      endcase
      m_prev[d] = x;
    end
    if (set_err)  m_err[d] = 1'b1;
    else if (clr) m_err[d] = 1'b0;
    e.d    = d;
    e.hi   = m_hi[d];
    e.lock = (m_state[d] == 2);
    e.err  = m_err[d];
  endtask

  task automatic drive(input int d, input bit v, input int x, input bit clr);
    exp_t e;
    cv[d] = v;
    ci[d] = 4'(x);
    ec[d] = clr;
    model(d, v, x, clr, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    cv[d] = 1'b0;
    ec[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cv[d] = 1'b0;
      ci[d] = 4'd0;
      ec[d] = 1'b0;
    end
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({hc[d], wp[d], cy[d], lk[d], se[d]} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d got %b want 00000000", d,
                 {hc[d], wp[d], cy[d], lk[d], se[d]});
      end
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_down_lock_wrap();
    drive(0, 1, 10, 0);
    drive(0, 1, 9, 0);
    drive(0, 1, 8, 0);
    n_tests++;
    if (lk[0] !== 1'b0) begin n_fail++; $display("FAIL down_prelock got %0b want 0", lk[0]); end
    drive(0, 1, 7, 0);
    n_tests++;
    if (lk[0] !== 1'b1) begin n_fail++; $display("FAIL down_lock got %0b want 1", lk[0]); end
    for (int v = 6; v >= 0; v--) drive(0, 1, v, 0);
    drive(0, 1, 10, 0);
    n_tests++;
    if (wp[0] !== 1'b1 || hc[0] !== 4'd1 || cy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_first_wrap got wrap=%0b hi=%0d carry=%0b want 1 1 0", wp[0], hc[0], cy[0]);
    end
    drive(0, 1, 9, 0);
    n_tests++;
    if (wp[0] !== 1'b0) begin n_fail++; $display("FAIL down_wrap_width got %0b want 0", wp[0]); end
    for (int w = 2; w <= 6; w++) begin
      for (int v = 8; v >= 0; v--) drive(0, 1, v, 0);
      drive(0, 1, 10, 0);
      n_tests++;
      if (hc[0] !== 4'(w % 6) || cy[0] !== (w == 6) || wp[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL down_wrap%0d got hi=%0d carry=%0b wrap=%0b want %0d %0b 1",
                 w, hc[0], cy[0], wp[0], w % 6, (w == 6));
      end
      drive(0, 1, 9, 0);
    end
  endtask

  task automatic test_up_config();
    for (int v = 0; v <= 10; v++) drive(1, 1, v, 0);
    n_tests++;
    if (lk[1] !== 1'b1 || hc[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL up_lock got locked=%0b hi=%0d want 1 0", lk[1], hc[1]);
    end
    drive(1, 1, 0, 0);
    n_tests++;
    if (wp[1] !== 1'b1 || hc[1] !== 4'd1) begin
      n_fail++;
      $display("FAIL up_wrap got wrap=%0b hi=%0d want 1 1", wp[1], hc[1]);
    end
    drive(1, 1, 1, 0);
    drive(1, 1, 2, 0);
    drive(1, 1, 11, 0);
    n_tests++;
    if (se[1] !== 1'b1 || lk[1] !== 1'b0 || hc[1] !== 4'd1) begin
      n_fail++;
      $display("FAIL up_range_err got err=%0b locked=%0b hi=%0d want 1 0 1", se[1], lk[1], hc[1]);
    end
  endtask

  task automatic test_preset_config();
    for (int v = 5; v <= 15; v++) drive(2, 1, v, 0);
    drive(2, 1, 5, 0);
    n_tests++;
    if (wp[2] !== 1'b1 || hc[2] !== 4'd1 || lk[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL preset_wrap got wrap=%0b hi=%0d locked=%0b want 1 1 1", wp[2], hc[2], lk[2]);
    end
    drive(2, 1, 6, 0);
    drive(2, 1, 3, 0);
    n_tests++;
    if (se[2] !== 1'b1 || lk[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL preset_low_err got err=%0b locked=%0b want 1 0", se[2], lk[2]);
    end
  endtask

  task automatic test_valid_gap();
    drive(0, 1, 8, 0);
    drive(0, 1, 7, 0);
    for (int g = 0; g < 4; g++) begin
      drive(0, 0, 3, 0);
      n_tests++;
      if (wp[0] !== 1'b0 || cy[0] !== 1'b0 || lk[0] !== 1'b1 || se[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_hold%0d got wrap=%0b carry=%0b locked=%0b err=%0b want 0 0 1 0",
                 g, wp[0], cy[0], lk[0], se[0]);
      end
    end
    drive(0, 1, 6, 0);
    n_tests++;
    if (se[0] !== 1'b0 || lk[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_resume got err=%0b locked=%0b want 0 1", se[0], lk[0]);
    end
  endtask

  task automatic test_err_clr();
    drive(0, 1, 2, 0);
    n_tests++;
    if (se[0] !== 1'b1 || lk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set got err=%0b locked=%0b want 1 0", se[0], lk[0]);
    end
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 10, 0);
    n_tests++;
    if (lk[0] !== 1'b1 || wp[0] !== 1'b0 || hc[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL acq_wrap_ignored got locked=%0b wrap=%0b hi=%0d want 1 0 0", lk[0], wp[0], hc[0]);
    end
    drive(0, 1, 4, 1);
    n_tests++;
    if (se[0] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got %0b want 1", se[0]); end
    drive(0, 0, 0, 1);
    n_tests++;
    if (se[0] !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %0b want 0", se[0]); end
  endtask

  task automatic test_back_to_back_reset();
    drive(1, 1, 0, 0);
    for (int v = 1; v <= 10; v++) drive(1, 1, v, 0);
    drive(1, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 10; v++) drive(1, 1, v, 0);
      drive(1, 1, 0, 0);
    end
    n_tests++;
    if (hc[1] !== 4'd4 || lk[1] !== 1'b1 || se[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got hi=%0d locked=%0b err=%0b want 4 1 1", hc[1], lk[1], se[1]);
    end
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({hc[1], wp[1], cy[1], lk[1], se[1]} !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b want 00000000", {hc[1], wp[1], cy[1], lk[1], se[1]});
    end
    #1 rst = 1'b1;
    drive(1, 1, 5, 0);
    drive(1, 1, 6, 0);
    drive(1, 1, 7, 0);
    n_tests++;
    if (lk[1] !== 1'b0) begin n_fail++; $display("FAIL relock_early got %0b want 0", lk[1]); end
    drive(1, 1, 8, 0);
    n_tests++;
    if (lk[1] !== 1'b1) begin n_fail++; $display("FAIL relock got %0b want 1", lk[1]); end
    drive(0, 1, 15, 0);
    drive(0, 1, 14, 0);
    n_tests++;
    if (se[0] !== 1'b0 || lk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_out_of_range got err=%0b locked=%0b want 0 0", se[0], lk[0]);
    end
  endtask

  initial begin
    test_reset();
    test_down_lock_wrap();
    test_up_config();
    test_preset_config();
    test_valid_gap();
    test_err_clr();
    test_back_to_back_reset();
    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
